// File: rtl/regfile_mp_pkg.sv
// Shared constants and FSM encoding for the multi-port register file.
package regfile_mp_pkg;

  localparam int unsigned DefXlen  = 32;
  localparam int unsigned DefNregs = 32;
  localparam int unsigned DefNrd   = 2;
  localparam int unsigned DefNwr   = 2;
  localparam int unsigned DefSpIdx = 2;
  localparam logic [31:0] DefSpInit = 32'h0200_0000;

  typedef enum logic {
    RfInit  = 1'b0,
    RfReady = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register pending-write bits; an issue on the same edge as a write-back wins.
module regfile_mp_scoreboard #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned NWR   = 2,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ready_i,
  input  logic              issue_vld_i,
  input  logic [AW-1:0]     issue_rd_i,
  input  logic [NWR-1:0]    we_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  output logic [NREGS-1:0]  busy_o
);

  logic [NREGS-1:0] busy_d, busy_q;

  always_comb begin
    busy_d = busy_q;
    if (ready_i) begin
      for (int p = 0; p < NWR; p++) begin
        if (we_i[p]) busy_d[wr_addr_i[p*AW +: AW]] = 1'b0;
      end
      if (issue_vld_i) busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD async reads with write forwarding, NWR sync writes, init sweep.
// Optional scoreboard enabled by defining REGFILE_SCOREBOARD_EN.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned      XLEN    = DefXlen,
  parameter int unsigned      NREGS   = DefNregs,
  parameter int unsigned      NRD     = DefNrd,
  parameter int unsigned      NWR     = DefNwr,
  parameter int unsigned      SP_IDX  = DefSpIdx,
  parameter logic [XLEN-1:0]  SP_INIT = XLEN'(DefSpInit),
  localparam int unsigned     AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  output logic                init_done,
  input  logic                issue_vld,
  input  logic [AW-1:0]       issue_rd,
  output logic [NREGS-1:0]    busy
);

  rf_state_e       state_q;
  logic [AW:0]     idx_q;
  logic            init_done_q;
  logic [XLEN-1:0] regs_q [NREGS];
  logic            ready;

  assign ready     = (state_q == RfReady);
  assign init_done = init_done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RfInit;
      idx_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        RfInit: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == (AW+1)'(NREGS - 1)) begin
            state_q     <= RfReady;
            init_done_q <= 1'b1;
          end
        end
        RfReady: begin
        end
        default: state_q <= RfInit;
      endcase
    end
  end

  // No reset on the array itself so it can map to LUTRAM; the sweep initialises it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == RfInit) begin
        regs_q[idx_q[AW-1:0]] <= (idx_q[AW-1:0] == AW'(SP_IDX)) ? SP_INIT : '0;
      end else begin
        // Later ports overwrite earlier ones, so the youngest write wins.
        for (int p = 0; p < NWR; p++) begin
          if (we[p] && wr_addr[p*AW +: AW] != '0) begin
            regs_q[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] fwd;

    assign ra = rd_addr[k*AW +: AW];

    always_comb begin
      fwd = regs_q[ra];
      for (int p = 0; p < NWR; p++) begin
        if (we[p] && wr_addr[p*AW +: AW] == ra) fwd = wr_data[p*XLEN +: XLEN];
      end
    end

    assign rd_data[k*XLEN +: XLEN] = (ready && ra != '0) ? fwd : '0;
  end

`ifdef REGFILE_SCOREBOARD_EN
  regfile_mp_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_scoreboard (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ready_i     (ready),
    .issue_vld_i (issue_vld),
    .issue_rd_i  (issue_rd),
    .we_i        (we),
    .wr_addr_i   (wr_addr),
    .busy_o      (busy)
  );
`else
  logic unused_issue;
  assign unused_issue = ^{issue_vld, issue_rd};
  assign busy         = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed plus randomized checks of regfile_mp against an array-based reference model.
module tb_regfile_mp;

  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;
  localparam logic [31:0] SP = 32'h0200_0000;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*32-1:0]   rd_data;
  logic [NWR-1:0]      we = '0;
  logic [NWR*AW-1:0]   wr_addr = '0;
  logic [NWR*32-1:0]   wr_data = '0;
  logic                init_done;
  logic                issue_vld = 1'b0;
  logic [AW-1:0]       issue_rd = '0;
  logic [NREGS-1:0]    busy;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .init_done (init_done),
    .issue_vld (issue_vld),
    .issue_rd  (issue_rd),
    .busy      (busy)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model [NREGS];
  logic [31:0] busy_m = '0;
  bit          ready_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Spec read rule: x0 -> 0, else youngest matching enabled write, else stored value.
  function automatic logic [31:0] exp_read(input int k);
    logic [AW-1:0] a;
    logic [31:0]   r;
    a = rd_addr[k*AW +: AW];
    if (!ready_m || a == 0) return 32'h0;
    r = model[a];
    for (int p = 0; p < NWR; p++)
      if (we[p] && wr_addr[p*AW +: AW] == a) r = wr_data[p*32 +: 32];
    return r;
  endfunction

  task automatic check_reads(input string tag);
    for (int k = 0; k < NRD; k++)
      check($sformatf("%s_rd%0d", tag, k), rd_data[k*32 +: 32], exp_read(k));
  endtask

  // Commit the current inputs to the model, then advance one edge.
  task automatic tick();
    if (ready_m) begin
      for (int p = 0; p < NWR; p++) begin
        if (we[p] && wr_addr[p*AW +: AW] != 0) model[wr_addr[p*AW +: AW]] = wr_data[p*32 +: 32];
`ifdef REGFILE_SCOREBOARD_EN
        if (we[p]) busy_m[wr_addr[p*AW +: AW]] = 1'b0;
`endif
      end
`ifdef REGFILE_SCOREBOARD_EN
      if (issue_vld) busy_m[issue_rd] = 1'b1;
`endif
      busy_m[0] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
    wr_addr[p*AW +: AW] = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic do_reset(input int hold);
    int cnt;
    rst_n   = 1'b0;
    ready_m = 1'b0;
    repeat (hold) tick();
    check("rst_init_done", {31'b0, init_done}, 32'h0);
    check("rst_busy", busy, 32'h0);
    busy_m = '0;
    rst_n  = 1'b1;
    // Junk traffic during the sweep must be ignored.
    we = 2'b11;
    set_wr(0, 5'd3, 32'hBAD0_0003);
    set_wr(1, 5'd5, 32'hBAD0_0005);
    issue_vld = 1'b1;
    issue_rd  = 5'd3;
    rd_addr   = {5'd3, 5'd2};
    cnt = 0;
    while (init_done !== 1'b1 && cnt < 64) begin
      check_reads("sweep");
      tick();
      cnt++;
    end
    check("init_latency", cnt, 32);
    we = '0;
    issue_vld = 1'b0;
    for (int r = 0; r < NREGS; r++) model[r] = 32'h0;
    model[2] = SP;
    ready_m  = 1'b1;
    busy_m   = '0;
    rd_addr  = {5'd5, 5'd2};
    #1;
    check("init_x2", rd_data[31:0], SP);
    check("init_x5", rd_data[63:32], 32'h0);
    rd_addr = {5'd3, 5'd3};
    #1;
    check("init_x3_ignored", rd_data[31:0], 32'h0);
    check("init_busy", busy, 32'h0);
  endtask

  initial begin
    do_reset(3);

    // Same-cycle forwarding, then array hold.
    we = 2'b01;
    set_wr(0, 5'd7, 32'hDEAD_BEEF);
    rd_addr = {5'd2, 5'd7};
    #1;
    check("fwd_same", rd_data[31:0], 32'hDEAD_BEEF);
    check_reads("fwd");
    tick();
    we = '0;
    #1;
    check("fwd_next", rd_data[31:0], 32'hDEAD_BEEF);

    // Same-address conflict: port 1 wins.
    we = 2'b11;
    set_wr(0, 5'd9, 32'h11);
    set_wr(1, 5'd9, 32'h22);
    rd_addr = {5'd9, 5'd9};
    #1;
    check("conflict_same", rd_data[31:0], 32'h22);
    tick();
    we = '0;
    #1;
    check("conflict_next", rd_data[63:32], 32'h22);

    // x0 stays zero.
    we = 2'b11;
    set_wr(0, 5'd0, 32'hFFFF_FFFF);
    set_wr(1, 5'd0, 32'hFFFF_FFFF);
    rd_addr = {5'd0, 5'd0};
    #1;
    check("x0_same", rd_data[31:0], 32'h0);
    tick();
    we = '0;
    #1;
    check("x0_next", rd_data[63:32], 32'h0);

`ifdef REGFILE_SCOREBOARD_EN
    issue_vld = 1'b1;
    issue_rd  = 5'd4;
    tick();
    check("sb_set", {31'b0, busy[4]}, 32'h1);
    we = 2'b01;
    set_wr(0, 5'd4, 32'h44);
    tick();
    check("sb_set_wins", {31'b0, busy[4]}, 32'h1);
    issue_vld = 1'b0;
    tick();
    we = '0;
    check("sb_clear", {31'b0, busy[4]}, 32'h0);
    issue_vld = 1'b1;
    issue_rd  = 5'd0;
    tick();
    issue_vld = 1'b0;
    check("sb_x0", {31'b0, busy[0]}, 32'h0);
`endif

    // Randomized traffic; narrow address range half the time to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      bit narrow;
      narrow = $urandom_range(0, 1) == 1;
      we = NWR'($urandom);
      for (int p = 0; p < NWR; p++)
        set_wr(p, AW'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31)), $urandom);
      for (int k = 0; k < NRD; k++)
        rd_addr[k*AW +: AW] = AW'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31));
      issue_vld = $urandom_range(0, 1) == 1;
      issue_rd  = AW'($urandom_range(0, 7));
      #1;
      check_reads("rand");
      check("rand_busy", busy, busy_m);
      tick();
    end
    we = '0;
    issue_vld = 1'b0;

    // Mid-operation reset for one cycle restarts the sweep.
    do_reset(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
